pwm_capture: RTL and testbench

Receive-side counterpart of the PWM generator: samples an incoming PWM waveform on `clk1ms`, measures high time, low time and period in clock cycles, and reports each completed period with a one-cycle `valid` strobe. It sits at the input of a control or monitoring path, for example in a loopback check of the generator's 2-high / 18-low pattern. A timeout reports a stuck-high or stuck-low input.

---
 rtl/pwm_capture_if.sv | 41 ++++
 rtl/pwm_capture.sv | 161 ++++++++++++++++
 tb/tb_pwm_capture.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: bundles the PWM input and the measurement results of
// pwm_capture.
//
// Handshake: valid-only, with no ready. The consumer cannot apply
// backpressure. valid is high for exactly one clk1ms cycle whenever
// high_time, low_time and period have just been updated. Between strobes
// those three values hold steady, so a consumer may sample them at any time.
//
// Signals:
//   pwm_in      - asynchronous PWM waveform under measurement
//   high_time   - high cycles of the last completed period (CW bits)
//   low_time    - low cycles of the last completed period (CW bits)
//   period      - high_time + low_time, full width (CW+1 bits)
//   valid       - one-cycle update strobe
//   stuck       - sticky timeout flag
//   stuck_level - level that timed out
//   state       - capture FSM state, for debug
//
// Modports: master = the capture block; slave = source/consumer side.
interface pwm_capture_if #(
  parameter int CW = 26
);
  logic          pwm_in;
  logic [CW-1:0] high_time;
  logic [CW-1:0] low_time;
  logic [CW:0]   period;
  logic          valid;
  logic          stuck;
  logic          stuck_level;
  logic [1:0]    state;

  modport master (
    input  pwm_in,
    output high_time, low_time, period, valid, stuck, stuck_level, state
  );

  modport slave (
    output pwm_in,
    input  high_time, low_time, period, valid, stuck, stuck_level, state
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform on clk1ms.
//
// The block synchronises pwm_in, then times each high level and each low
// level in clock cycles. Every period that completes (a high, then a low,
// closed by the next rise) is reported with a one-cycle valid strobe. If a
// level lasts TIMEOUT cycles, the block raises the sticky stuck flag and
// returns to IDLE.
//
// Ports:
//   clk1ms - single clock, rising edge
//   reset  - asynchronous, active-low reset
//   cap    - pwm_capture_if master modport: pwm_in in; measurements,
//            valid, stuck, stuck_level and debug state out
//
// Parameters:
//   CW      - width of the high/low counters
//   TIMEOUT - stuck threshold in cycles, 2 <= TIMEOUT <= 2**CW-1
module pwm_capture #(
  parameter int CW      = 26,
  parameter int TIMEOUT = 1000
) (
  input  logic         clk1ms,
  input  logic         reset,
  pwm_capture_if.master cap
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    LOW  = 2'b10
  } state_e;

  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  // Synchroniser (s1, s2) plus history flop s3 for edge detection.
  logic       s1_q, s2_q, s3_q;
  logic [1:0] settle_q;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] hi_lat_q, hi_lat_d;
  logic [CW-1:0] high_q, high_d;
  logic [CW-1:0] low_q, low_d;
  logic [CW:0]   period_q, period_d;
  logic          valid_q, valid_d;
  logic          stuck_q, stuck_d;
  logic          stuck_lvl_q, stuck_lvl_d;

  logic edge_en, rise, fall;

  // The synchroniser starts at 0 on release. If pwm_in is already high,
  // s2 rises before s3 and looks like an edge. Masking edges until
  // settle_q saturates suppresses that false rise.
  assign edge_en = (settle_q == 2'd3);
  assign rise    = edge_en &  s2_q & ~s3_q;
  assign fall    = edge_en & ~s2_q &  s3_q;

  always_ff @(posedge clk1ms or negedge reset) begin
    if (!reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      settle_q <= 2'd0;
    end else begin
      s1_q <= cap.pwm_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
    end
  end

  always_ff @(posedge clk1ms or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_lat_q    <= '0;
      high_q      <= '0;
      low_q       <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      stuck_q     <= 1'b0;
      stuck_lvl_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_lat_q    <= hi_lat_d;
      high_q      <= high_d;
      low_q       <= low_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      stuck_q     <= stuck_d;
      stuck_lvl_q <= stuck_lvl_d;
    end
  end

  // cnt counts the cycles of the current level. An edge restarts cnt at 1,
  // because the edge cycle itself is the first cycle of the new level. The
  // timeout compare therefore only matters on cycles with no edge, so the
  // edge always wins over the timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_lat_d    = hi_lat_q;
    high_d      = high_q;
    low_d       = low_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    stuck_d     = stuck_q;
    stuck_lvl_d = stuck_lvl_q;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          cnt_d   = ONE_C;
          stuck_d = 1'b0;
        end
      end
      HIGH: begin
        if (fall) begin
          hi_lat_d = cnt_q;
          cnt_d    = ONE_C;
          state_d  = LOW;
        end else if (cnt_q == TIMEOUT_C) begin
          stuck_d     = 1'b1;
          stuck_lvl_d = s2_q;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      LOW: begin
        if (rise) begin
          high_d   = hi_lat_q;
          low_d    = cnt_q;
          period_d = {1'b0, hi_lat_q} + {1'b0, cnt_q};
          valid_d  = 1'b1;
          cnt_d    = ONE_C;
          state_d  = HIGH;
        end else if (cnt_q == TIMEOUT_C) begin
          stuck_d     = 1'b1;
          stuck_lvl_d = s2_q;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cap.high_time   = high_q;
  assign cap.low_time    = low_q;
  assign cap.period      = period_q;
  assign cap.valid       = valid_q;
  assign cap.stuck       = stuck_q;
  assign cap.stuck_level = stuck_lvl_q;
  assign cap.state       = state_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed testbench for pwm_capture.
//
// The stimulus tasks drive pwm_in one level at a time, changing it on the
// falling clock edge. Before driving each period, the stimulus pushes that
// period's hand-computed {high, low, period} record into exp_q. A separate
// monitor pops exp_q on each valid and compares the record against the DUT
// outputs. The main sequence also makes directed checks of reset values,
// stuck behaviour and FSM state.
module tb_pwm_capture;
  localparam int CW      = 26;
  localparam int TIMEOUT = 1000;
  localparam int W       = 3 * CW + 1;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_HIGH = 2'b01;

  logic clk1ms = 1'b0;
  logic reset  = 1'b0;

  pwm_capture_if #(.CW(CW)) cap_if ();

  pwm_capture #(.CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .clk1ms (clk1ms),
    .reset  (reset),
    .cap    (cap_if)
  );

  // Clock / reset block
  always #5 clk1ms = ~clk1ms;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  int cyc = 0;
  int gap_exp = 0;
  bit gap_armed = 1'b0;
  int last_valid_cyc = 0;
  logic [W-1:0] mon_act;

  always @(posedge clk1ms) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rec(input int h, input int l);
    logic [CW-1:0] hh;
    logic [CW-1:0] ll;
    logic [CW:0]   pp;
    hh = CW'(h);
    ll = CW'(l);
    pp = (CW+1)'(h + l);
    return {hh, ll, pp};
  endfunction

  // Driver tasks
  task automatic hold(input logic lvl, input int n);
    cap_if.pwm_in = lvl;
    repeat (n) @(negedge clk1ms);
  endtask

  task automatic stream(input int h, input int l, input int n);
    repeat (n) begin
      hold(1'b1, h);
      hold(1'b0, l);
    end
  endtask

  task automatic push(input int h, input int l, input int n);
    repeat (n) exp_q.push_back(rec(h, l));
  endtask

  // Assert reset and check that the outputs clear at once, before any
  // clock edge. Then hold reset for three cycles and release it.
  task automatic do_reset(input logic lvl);
    reset = 1'b0;
    cap_if.pwm_in = lvl;
    #1;
    check("rst_high_time",   cap_if.high_time,   0);
    check("rst_low_time",    cap_if.low_time,    0);
    check("rst_period",      cap_if.period,      0);
    check("rst_valid",       cap_if.valid,       0);
    check("rst_stuck",       cap_if.stuck,       0);
    check("rst_stuck_level", cap_if.stuck_level, 0);
    check("rst_state",       cap_if.state,       S_IDLE);
    repeat (3) @(negedge clk1ms);
    reset = 1'b1;
  endtask

  // Scoreboard monitor
  always @(negedge clk1ms) begin
    if (reset && cap_if.valid) begin
      mon_act = {cap_if.high_time, cap_if.low_time, cap_if.period};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: actual=valid with %0d/%0d/%0d required=no valid (t=%0t)",
                 cap_if.high_time, cap_if.low_time, cap_if.period, $time);
      end else begin
        check("measurement", mon_act, exp_q.pop_front());
      end
      if (gap_exp != 0 && gap_armed) check("valid_gap", cyc - last_valid_cyc, gap_exp);
      last_valid_cyc = cyc;
      gap_armed = 1'b1;
    end
  end

  // Watchdog
  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: actual=timeout required=sequence complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    cap_if.pwm_in = 1'b0;
    @(negedge clk1ms);

    // 1: generator pattern 2 high / 18 low
    do_reset(1'b0);
    hold(1'b0, 5);
    gap_exp = 20;
    gap_armed = 1'b0;
    push(2, 18, 5);
    stream(2, 18, 5);
    hold(1'b1, 2);
    hold(1'b0, 6);
    check("t1_drained", exp_q.size(), 0);
    gap_exp = 0;

    // 2: pwm_in high through reset release, then 5 low / 3 high / 4 low / rise
    do_reset(1'b1);
    hold(1'b1, 10);
    check("t2_no_rise_state", cap_if.state, S_IDLE);
    hold(1'b0, 5);
    push(3, 4, 1);
    hold(1'b1, 3);
    hold(1'b0, 4);
    hold(1'b1, 1);
    hold(1'b0, 6);
    check("t2_drained", exp_q.size(), 0);

    // 3: stuck high. The rise closes the 1/6 period and enters HIGH 3 cycles later.
    push(1, 6, 1);
    hold(1'b1, 1002);
    check("t3_stuck_before", cap_if.stuck, 0);
    check("t3_state_high",   cap_if.state, S_HIGH);
    hold(1'b1, 1);
    check("t3_stuck",        cap_if.stuck,       1);
    check("t3_stuck_level",  cap_if.stuck_level, 1);
    check("t3_state_idle",   cap_if.state,       S_IDLE);
    check("t3_keep_high",    cap_if.high_time,   1);
    check("t3_keep_low",     cap_if.low_time,    6);
    check("t3_keep_period",  cap_if.period,      7);
    hold(1'b1, 20);
    check("t3_stuck_sticky", cap_if.stuck, 1);
    hold(1'b0, 5);
    hold(1'b1, 2);
    check("t3_stuck_not_yet", cap_if.stuck, 1);
    hold(1'b1, 1);
    check("t3_stuck_cleared", cap_if.stuck, 0);
    check("t3_rearm_state",   cap_if.state, S_HIGH);

    // 4: a 999-cycle low still measures; a 1100-cycle low times out low
    push(3, 999, 1);
    hold(1'b0, 999);
    hold(1'b1, 1);
    hold(1'b0, 1100);
    check("t4_stuck",       cap_if.stuck,       1);
    check("t4_stuck_level", cap_if.stuck_level, 0);
    check("t4_state_idle",  cap_if.state,       S_IDLE);
    check("t4_keep_high",   cap_if.high_time,   3);
    check("t4_keep_low",    cap_if.low_time,    999);
    check("t4_keep_period", cap_if.period,      1002);
    check("t4_drained",     exp_q.size(),       0);

    // 5: minimum pulses 1 high / 1 low
    gap_exp = 2;
    gap_armed = 1'b0;
    push(1, 1, 10);
    stream(1, 1, 10);
    hold(1'b1, 1);
    hold(1'b0, 6);
    check("t5_stuck_clear", cap_if.stuck, 0);
    check("t5_drained",     exp_q.size(), 0);
    gap_exp = 0;

    // 6: reset during LOW of a 2/18 stream
    push(1, 6, 1);
    push(2, 18, 1);
    hold(1'b1, 2);
    hold(1'b0, 18);
    hold(1'b1, 2);
    hold(1'b0, 8);
    check("t6_pre_reset_period", cap_if.period, 20);
    check("t6_pre_reset_drained", exp_q.size(), 0);
    do_reset(1'b0);
    hold(1'b0, 5);
    push(2, 18, 2);
    stream(2, 18, 2);
    hold(1'b1, 2);
    hold(1'b0, 6);
    check("t6_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
